// File: rtl/ysyx_lsu_l1d.sv
// Load/store unit with a direct-mapped, write-through, write-update L1 data cache (one word per line).
// Optional macro YSYX_L1D_PERF_EN adds cacheable-load hit/miss counters (perf_hit_o, perf_miss_o).
module ysyx_lsu_l1d #(
  parameter int BIT_W   = 32,
  parameter int L1D_LEN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lsu_avalid,
  input  logic             ren,
  input  logic             wen,
  input  logic [BIT_W-1:0] addr,
  input  logic [3:0]       alu_op,
  input  logic [BIT_W-1:0] wdata,
  input  logic             flush_i,
  output logic [BIT_W-1:0] rdata_o,
  output logic             rvalid_o,
  output logic             wready_o,
  output logic [BIT_W-1:0] lsu_araddr_o,
  output logic             lsu_arvalid_o,
  output logic [7:0]       lsu_rstrb_o,
  input  logic [BIT_W-1:0] lsu_rdata,
  input  logic             lsu_rvalid,
  output logic [BIT_W-1:0] lsu_awaddr_o,
  output logic             lsu_awvalid_o,
  output logic [BIT_W-1:0] lsu_wdata_o,
  output logic [7:0]       lsu_wstrb_o,
  output logic             lsu_wvalid_o,
  input  logic             lsu_wready
`ifdef YSYX_L1D_PERF_EN
  ,
  output logic [31:0]      perf_hit_o,
  output logic [31:0]      perf_miss_o
`endif
);

  localparam logic [3:0] YSYX_ALU_OP_LB  = 4'd0;
  localparam logic [3:0] YSYX_ALU_OP_LH  = 4'd1;
  localparam logic [3:0] YSYX_ALU_OP_LW  = 4'd2;
  localparam logic [3:0] YSYX_ALU_OP_LBU = 4'd4;
  localparam logic [3:0] YSYX_ALU_OP_LHU = 4'd5;
  localparam logic [3:0] YSYX_ALU_OP_SB  = 4'd8;
  localparam logic [3:0] YSYX_ALU_OP_SH  = 4'd9;
  localparam logic [3:0] YSYX_ALU_OP_SW  = 4'd10;

  localparam int L1D_SIZE = 1 << L1D_LEN;
  localparam int IDX_W    = (L1D_LEN > 0) ? L1D_LEN : 1;
  localparam int TAG_W    = BIT_W - L1D_LEN - 2;

  typedef enum logic [1:0] {IDLE, LD_BUS, ST_BUS, RESP} state_t;

  state_t state_q, state_nx;

  function automatic logic [3:0] base_strb(input logic [3:0] op);
    case (op)
      YSYX_ALU_OP_LB, YSYX_ALU_OP_LBU, YSYX_ALU_OP_SB: base_strb = 4'h1;
      YSYX_ALU_OP_LH, YSYX_ALU_OP_LHU, YSYX_ALU_OP_SH: base_strb = 4'h3;
      default:                                        base_strb = 4'hf;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [3:0] op, input logic [1:0] lo);
    case (base_strb(op))
      4'h1:    is_aligned = 1'b1;
      4'h3:    is_aligned = (lo[0] == 1'b0);
      default: is_aligned = (lo == 2'b00);
    endcase
  endfunction

  function automatic logic in_cache_range(input logic [BIT_W-1:0] a);
    in_cache_range = (a >= 32'h3000_0000 && a < 32'h4000_0000) ||
                     (a >= 32'h8000_0000 && a < 32'h8040_0000) ||
                     (a >= 32'hA000_0000 && a < 32'hC000_0000);
  endfunction

  // Cache storage
  logic [L1D_SIZE-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q  [L1D_SIZE];
  logic [BIT_W-1:0]    data_q [L1D_SIZE];

  // Request capture
  logic [BIT_W-1:0] req_addr;
  logic [3:0]       req_op;
  logic [BIT_W-1:0] req_wdata;
  logic             req_load;
  logic             req_cache;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [BIT_W-1:0] word_q;

  logic [IDX_W-1:0] idx_in;
  logic [TAG_W-1:0] tag_in;
  logic             cache_in;
  logic             hit_in;
  logic             accept;

  generate
    if (L1D_LEN == 0) begin : g_idx_none
      assign idx_in = '0;
    end else begin : g_idx
      assign idx_in = addr[L1D_LEN+1:2];
    end
  endgenerate

  assign tag_in   = addr[BIT_W-1:L1D_LEN+2];
  assign cache_in = in_cache_range(addr) && is_aligned(alu_op, addr[1:0]);
  assign hit_in   = cache_in && valid_q[idx_in] && (tag_q[idx_in] == tag_in);
  assign accept   = (state_q == IDLE) && lsu_avalid && (ren ^ wen);

  // Store datapath and line merge
  logic [BIT_W-1:0] st_wdata;
  logic [7:0]       st_strb;
  logic [BIT_W-1:0] st_merged;
  logic             fill_en;
  logic             upd_en;

  assign st_wdata = req_wdata << {req_addr[1:0], 3'b000};
  assign st_strb  = {4'b0000, base_strb(req_op)} << req_addr[1:0];
  assign fill_en  = (state_q == LD_BUS) && lsu_rvalid && req_cache;
  assign upd_en   = (state_q == ST_BUS) && lsu_wready && req_cache &&
                    valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  always_comb begin
    st_merged = data_q[req_idx];
    for (int unsigned b = 0; b < 4; b++) begin
      if (st_strb[b]) st_merged[8*b +: 8] = st_wdata[8*b +: 8];
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (wen)         state_nx = ST_BUS;
          else if (hit_in) state_nx = RESP;
          else             state_nx = LD_BUS;
        end
      end
      LD_BUS:  if (lsu_rvalid) state_nx = RESP;
      ST_BUS:  if (lsu_wready) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      req_addr  <= '0;
      req_op    <= '0;
      req_wdata <= '0;
      req_load  <= 1'b0;
      req_cache <= 1'b0;
      req_idx   <= '0;
      req_tag   <= '0;
      word_q    <= '0;
    end else begin
      if (accept) begin
        req_addr  <= addr;
        req_op    <= alu_op;
        req_wdata <= wdata;
        req_load  <= ren;
        req_cache <= cache_in;
        req_idx   <= idx_in;
        req_tag   <= tag_in;
        word_q    <= data_q[idx_in];
      end
      if ((state_q == LD_BUS) && lsu_rvalid) word_q <= lsu_rdata;
    end
  end

  // Flush takes priority over a same-cycle fill so the line stays invalid
  always_ff @(posedge clk) begin
    if (!rst)          valid_q <= '0;
    else if (flush_i)  valid_q <= '0;
    else if (fill_en)  valid_q[req_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst && !flush_i) begin
      if (fill_en) begin
        tag_q[req_idx]  <= req_tag;
        data_q[req_idx] <= lsu_rdata;
      end else if (upd_en) begin
        data_q[req_idx] <= st_merged;
      end
    end
  end

`ifdef YSYX_L1D_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_hit_o  <= '0;
      perf_miss_o <= '0;
    end else if (accept && ren && cache_in) begin
      if (hit_in) perf_hit_o  <= perf_hit_o + 32'd1;
      else        perf_miss_o <= perf_miss_o + 32'd1;
    end
  end
`endif

  // FSM: outputs
  logic [BIT_W-1:0] ld_shift;
  assign ld_shift = word_q >> {req_addr[1:0], 3'b000};

  always_comb begin
    rdata_o       = '0;
    rvalid_o      = 1'b0;
    wready_o      = 1'b0;
    lsu_araddr_o  = '0;
    lsu_arvalid_o = 1'b0;
    lsu_rstrb_o   = '0;
    lsu_awaddr_o  = '0;
    lsu_awvalid_o = 1'b0;
    lsu_wdata_o   = '0;
    lsu_wstrb_o   = '0;
    lsu_wvalid_o  = 1'b0;
    case (state_q)
      LD_BUS: begin
        lsu_arvalid_o = 1'b1;
        if (req_cache) begin
          lsu_araddr_o = {req_addr[BIT_W-1:2], 2'b00};
          lsu_rstrb_o  = 8'h0f;
        end else begin
          lsu_araddr_o = req_addr;
          lsu_rstrb_o  = {4'b0000, base_strb(req_op)};
        end
      end
      ST_BUS: begin
        lsu_awvalid_o = 1'b1;
        lsu_wvalid_o  = 1'b1;
        lsu_awaddr_o  = req_addr;
        lsu_wdata_o   = st_wdata;
        lsu_wstrb_o   = st_strb;
      end
      RESP: begin
        if (req_load) begin
          rvalid_o = 1'b1;
          case (req_op)
            YSYX_ALU_OP_LB:  rdata_o = {{(BIT_W-8){ld_shift[7]}}, ld_shift[7:0]};
            YSYX_ALU_OP_LBU: rdata_o = {{(BIT_W-8){1'b0}}, ld_shift[7:0]};
            YSYX_ALU_OP_LH:  rdata_o = {{(BIT_W-16){ld_shift[15]}}, ld_shift[15:0]};
            YSYX_ALU_OP_LHU: rdata_o = {{(BIT_W-16){1'b0}}, ld_shift[15:0]};
            default:         rdata_o = ld_shift;
          endcase
        end else begin
          wready_o = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
